timer_arbiter: RTL and testbench

TIMER_ARBITER -- requirements
Module: timer_arbiter

---
 rtl/timer_arbiter.sv | 103 ++++++++++
 tb/tb_timer_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/timer_arbiter.sv
// timer_arbiter: shares one N-bit up-counter among four requesters.
// Grants go round-robin; the owner counts to its sampled delay, then gets a one-cycle done pulse.
module timer_arbiter #(
    parameter int N = 3
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [3:0]     req,
    input  logic [4*N-1:0] delay_in,
    output logic [3:0]     gnt,
    output logic [3:0]     done,
    output logic           busy,
    output logic [N-1:0]   count_out
);
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t       r_state, w_state;
    logic [3:0]   r_gnt, w_gnt, r_done, w_done;
    logic [N-1:0] r_count, w_count, r_target, w_target;
    logic [1:0]   r_ptr, w_ptr, r_owner, w_owner, w_win, w_idx;
    logic         w_found;

    // Search starts just after the last owner; k = 4 wraps back to the last owner itself.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = r_ptr;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_state  = r_state;
        w_gnt    = r_gnt;
        w_done   = 4'b0;
        w_count  = r_count;
        w_target = r_target;
        w_ptr    = r_ptr;
        w_owner  = r_owner;
        case (r_state)
            IDLE: begin
                w_gnt   = 4'b0;
                w_count = '0;
                if (w_found) begin
                    w_gnt    = 4'b1 << w_win;
                    w_target = delay_in[w_win*N +: N];
                    w_owner  = w_win;
                    w_state  = COUNT;
                end
            end
            COUNT: begin
                // A dropped request wins over a terminal-count match.
                if (!req[r_owner]) begin
                    w_gnt   = 4'b0;
                    w_count = '0;
                    w_ptr   = r_owner;
                    w_state = IDLE;
                end else if (r_count == r_target) begin
                    w_gnt   = 4'b0;
                    w_done  = 4'b1 << r_owner;
                    w_ptr   = r_owner;
                    w_state = DONE;
                end else begin
                    w_count = r_count + 1'b1;
                end
            end
            default: begin
                w_count = '0;
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_gnt    <= 4'b0;
            r_done   <= 4'b0;
            r_count  <= '0;
            r_target <= '0;
            r_ptr    <= 2'd3;
            r_owner  <= 2'd0;
        end else begin
            r_state  <= w_state;
            r_gnt    <= w_gnt;
            r_done   <= w_done;
            r_count  <= w_count;
            r_target <= w_target;
            r_ptr    <= w_ptr;
            r_owner  <= w_owner;
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign busy      = (r_state != IDLE);
    assign count_out = r_count;
endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: randomized transactions against a transaction-level round-robin model.
// The stimulus queues expected grant records; the monitor reconstructs each grant and compares.
module tb_timer_arbiter;
    localparam int N = 3;
    typedef logic [4*N-1:0] dl_t;
    typedef struct {int who; int len; bit fin;} exp_t;

    logic         clk = 1'b0;
    logic         rstn;
    logic [3:0]   req;
    dl_t          delay_in;
    logic [3:0]   gnt, done;
    logic         busy;
    logic [N-1:0] count_out;

    exp_t       exp_q[$];
    exp_t       e;
    int         checks = 0, errors = 0;
    int         rr_ptr = 3;
    bit         active = 0;
    int         cur = 0, len = 0;
    logic [3:0] prev_done = 4'b0;

    always #5 clk = ~clk;

    timer_arbiter #(.N(N)) dut (
        .clk(clk), .rstn(rstn), .req(req), .delay_in(delay_in),
        .gnt(gnt), .done(done), .busy(busy), .count_out(count_out)
    );

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r);
        for (int k = 1; k <= 4; k++)
            if (r[(rr_ptr + k) % 4]) return (rr_ptr + k) % 4;
        return -1;
    endfunction

    // Monitor: every COUNT cycle shows gnt, every DONE cycle shows done, so idle is neither.
    always @(negedge clk) begin
        if (!rstn) begin
            active    = 0;
            len       = 0;
            prev_done = 4'b0;
        end else begin
            chk("outputs_legal", int'($onehot0(gnt) && $onehot0(done) && !((|gnt) && (|done))), 1);
            chk("busy", int'(busy), int'((|gnt) || (|done)));
            if (prev_done != 4'b0) chk("done_width", done, 0);
            if (gnt != 4'b0) begin
                if (!active) begin
                    active = 1;
                    cur    = gnt;
                    len    = 0;
                end
                chk("gnt_stable", gnt, cur);
                chk("count_seq", count_out, len);
                len++;
            end else if (active) begin
                active = 0;
                if (exp_q.size() == 0) chk("unexpected_grant", cur, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("grant_who", cur, 1 << e.who);
                    chk("grant_len", len, e.len);
                    chk("done_pulse", done, e.fin ? (1 << e.who) : 0);
                    if (!e.fin) chk("abort_count", count_out, 0);
                end
            end else if (done != 4'b0) chk("stray_done", done, 0);
            prev_done = done;
        end
    end

    // ab: -1 run to completion, -2 random abort point, >=0 drop the request when count_out == ab.
    task automatic run_txn(input logic [3:0] r, input dl_t dl, input int ab);
        int w, d, n;
        w = pick(r);
        d = int'(dl[w*N +: N]);
        if (ab == -2) ab = $urandom_range(0, d);
        exp_q.push_back('{w, (ab < 0) ? d + 1 : ab + 1, ab < 0});
        rr_ptr   = w;
        req      = r;
        delay_in = dl;
        n = (ab < 0) ? d + 1 : ab;
        repeat (n) begin
            @(negedge clk);
            req      = 4'($urandom) | 4'(1 << w);
            delay_in = dl_t'($urandom);
        end
        @(negedge clk);
        req = 4'b0;
        @(negedge clk);
    endtask

    task automatic run_hold(input int grants);
        int w;
        req      = 4'hF;
        delay_in = '0;
        for (int i = 0; i < grants; i++) begin
            w = pick(4'hF);
            exp_q.push_back('{w, 1, 1'b1});
            rr_ptr = w;
        end
        repeat (3 * grants) @(negedge clk);
        req = 4'b0;
        @(negedge clk);
    endtask

    initial begin
        rstn     = 1'b0;
        req      = 4'b0;
        delay_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_gnt", gnt, 0);
        chk("reset_done", done, 0);
        chk("reset_count", count_out, 0);
        chk("reset_busy", int'(busy), 0);
        #2 rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_gnt", gnt, 0);
            chk("idle_busy", int'(busy), 0);
        end

        run_txn(4'b0001, dl_t'(3), -1);
        run_hold(5);
        run_txn(4'b0100, dl_t'(7 << (2 * N)), -1);
        run_txn(4'b0010, dl_t'(5 << N), 2);
        run_txn(4'b1111, dl_t'($urandom), -1);
        run_txn(4'b0001, {4{3'd6}}, -1);
        run_txn(4'b0010, dl_t'(4 << N), 4);

        req      = 4'b0010;
        delay_in = dl_t'(6 << N);
        repeat (5) @(negedge clk);
        chk("pre_reset_count", count_out, 4);
        #2 rstn = 1'b0;
        #1;
        chk("async_gnt", gnt, 0);
        chk("async_done", done, 0);
        chk("async_count", count_out, 0);
        chk("async_busy", int'(busy), 0);
        req    = 4'b0;
        rr_ptr = 3;
        @(negedge clk);
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        run_txn(4'b1001, dl_t'($urandom), -1);

        repeat (150) run_txn(4'($urandom_range(1, 15)), dl_t'($urandom),
                             ($urandom_range(0, 2) == 0) ? -2 : -1);
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("no_open_grant", int'(active), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
